// File: rtl/bel_avl_ram_burst.sv
// Avalon-MM burst-capable slave RAM model: byte enables, pipelined reads, bulk load/unload.
// Optional protocol checker enabled by defining BEL_AVL_RAM_PROTO_CHECK_EN (adds proto_err).
module bel_avl_ram_burst #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned SIZE        = 64,
    parameter int unsigned ADR_WIDTH   = 6,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned BURST_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [ADR_WIDTH-1:0]     address,
    input  logic [BURST_WIDTH-1:0]   burstcount,
    input  logic [DWIDTH/8-1:0]      byteenable,
    input  logic [DWIDTH-1:0]        writedata,
    input  logic                     read,
    input  logic                     write,
    output logic                     waitrequest,
    output logic [DWIDTH-1:0]        readdata,
    output logic                     readdatavalid,
    input  logic                     i_write_all,
    input  logic [SIZE*DWIDTH-1:0]   i_in_ram,
    output logic [SIZE*DWIDTH-1:0]   o_out_ram
`ifdef BEL_AVL_RAM_PROTO_CHECK_EN
    ,
    output logic                     proto_err
`endif
);

    localparam int unsigned NBYTES = DWIDTH / 8;

    typedef enum logic [1:0] {StIdle, StRdBurst, StWrBurst} state_e;

    state_e                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   addr_q, addr_d;
    logic [BURST_WIDTH-1:0] remain_q, remain_d;
    logic [BURST_WIDTH-1:0] bc_eff;
    logic                   rd_issue;
    logic [ADR_WIDTH-1:0]   rd_addr;
    logic [DWIDTH-1:0]      rd_word;
    logic                   wr_en;
    logic [ADR_WIDTH-1:0]   wr_addr;
    logic                   load_en;

    logic [DWIDTH-1:0]      mem_q [SIZE];
    logic [RD_LATENCY-1:0]  vld_q;
    logic [DWIDTH-1:0]      dat_q [RD_LATENCY];

    function automatic logic in_range(input logic [ADR_WIDTH-1:0] a);
        return 32'(a) < SIZE;
    endfunction

    // Wraps modulo SIZE, which need not be a power of two.
    function automatic logic [ADR_WIDTH-1:0] addr_inc(input logic [ADR_WIDTH-1:0] a);
        if (32'(a) + 32'd1 == SIZE) return '0;
        return a + ADR_WIDTH'(1);
    endfunction

    assign bc_eff      = (burstcount == '0) ? BURST_WIDTH'(1) : burstcount;
    assign waitrequest = (state_q == StRdBurst);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        rd_issue = 1'b0;
        rd_addr  = addr_q;
        wr_en    = 1'b0;
        wr_addr  = addr_q;
        load_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (write) begin
                    // Write has priority over a simultaneous read.
                    wr_en   = 1'b1;
                    wr_addr = address;
                    if (bc_eff > BURST_WIDTH'(1)) begin
                        state_d  = StWrBurst;
                        addr_d   = addr_inc(address);
                        remain_d = bc_eff - BURST_WIDTH'(1);
                    end
                end else begin
                    load_en = i_write_all;
                    if (read) begin
                        rd_issue = 1'b1;
                        rd_addr  = address;
                        if (bc_eff > BURST_WIDTH'(1)) begin
                            state_d  = StRdBurst;
                            addr_d   = addr_inc(address);
                            remain_d = bc_eff - BURST_WIDTH'(1);
                        end
                    end
                end
            end
            StRdBurst: begin
                rd_issue = 1'b1;
                addr_d   = addr_inc(addr_q);
                remain_d = remain_q - BURST_WIDTH'(1);
                if (remain_q == BURST_WIDTH'(1)) state_d = StIdle;
            end
            StWrBurst: begin
                if (write) begin
                    wr_en    = 1'b1;
                    addr_d   = addr_inc(addr_q);
                    remain_d = remain_q - BURST_WIDTH'(1);
                    if (remain_q == BURST_WIDTH'(1)) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (load_en) begin
            for (int i = 0; i < SIZE; i++) mem_q[i] <= i_in_ram[i*DWIDTH +: DWIDTH];
        end else if (wr_en && in_range(wr_addr)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byteenable[b]) mem_q[wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

    assign rd_word = in_range(rd_addr) ? mem_q[rd_addr] : '0;

    // Data is captured at issue; stages only load behind a valid so readdata holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_issue;
            if (rd_issue) dat_q[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign readdatavalid = vld_q[RD_LATENCY-1];
    assign readdata      = dat_q[RD_LATENCY-1];

    always_comb begin
        for (int i = 0; i < SIZE; i++) o_out_ram[i*DWIDTH +: DWIDTH] = mem_q[i];
    end

`ifdef BEL_AVL_RAM_PROTO_CHECK_EN
    logic c_both, c_oor, c_wait, c_bulk;

    always_comb begin
        c_both = (state_q == StIdle) && read && write;
        c_oor  = (state_q == StIdle) && (read || write) && !in_range(address);
        c_wait = waitrequest && (read || write);
        c_bulk = i_write_all && !((state_q == StIdle) && !write);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) proto_err <= 1'b0;
        else if (c_both || c_oor || c_wait || c_bulk) proto_err <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (c_both) $display("%0t bel_avl_ram_burst: read and write both high", $time);
        if (c_oor)  $display("%0t bel_avl_ram_burst: out-of-range address %0d", $time, address);
        if (c_wait) $display("%0t bel_avl_ram_burst: request during waitrequest", $time);
        if (c_bulk) $display("%0t bel_avl_ram_burst: bulk load ignored (bus busy)", $time);
    end
`endif
`endif

endmodule

// File: tb/tb_bel_avl_ram_burst.sv
// Directed, table-driven bench for bel_avl_ram_burst (default build, RD_LATENCY=3).
module tb_bel_avl_ram_burst;

    localparam int DW  = 32;
    localparam int SZ  = 64;
    localparam int AW  = 6;
    localparam int LAT = 3;
    localparam int BW  = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [AW-1:0]     address;
    logic [BW-1:0]     burstcount;
    logic [DW/8-1:0]   byteenable;
    logic [DW-1:0]     writedata;
    logic              read, write;
    logic              waitrequest;
    logic [DW-1:0]     readdata;
    logic              readdatavalid;
    logic              i_write_all;
    logic [SZ*DW-1:0]  i_in_ram;
    logic [SZ*DW-1:0]  o_out_ram;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic          is_rd;
        logic [AW-1:0] adr;
        logic [BW-1:0] bc;
        logic [3:0]    be;
        logic [31:0]   wd;
        logic [31:0]   exp;
    } vec_t;

    vec_t vecs [12];

    bel_avl_ram_burst #(
        .DWIDTH(DW), .SIZE(SZ), .ADR_WIDTH(AW), .RD_LATENCY(LAT), .BURST_WIDTH(BW)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .address      (address),
        .burstcount   (burstcount),
        .byteenable   (byteenable),
        .writedata    (writedata),
        .read         (read),
        .write        (write),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .i_write_all  (i_write_all),
        .i_in_ram     (i_in_ram),
        .o_out_ram    (o_out_ram)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return o_out_ram[i*DW +: DW];
    endfunction

    initial begin
        rst_n_i     = 1'b0;
        address     = '0;
        burstcount  = 4'd1;
        byteenable  = 4'hF;
        writedata   = '0;
        read        = 1'b0;
        write       = 1'b0;
        i_write_all = 1'b0;
        i_in_ram    = '1;

        vecs[0]  = '{1'b0, 6'd5,  4'd1, 4'b0101, 32'hA5A5_1234, 32'hFFA5_FF34};
        vecs[1]  = '{1'b1, 6'd5,  4'd1, 4'b0000, 32'h0,         32'hFFA5_FF34};
        vecs[2]  = '{1'b0, 6'd10, 4'd1, 4'b1111, 32'h1122_3344, 32'h1122_3344};
        vecs[3]  = '{1'b0, 6'd10, 4'd1, 4'b1000, 32'hAABB_CCDD, 32'hAA22_3344};
        vecs[4]  = '{1'b1, 6'd10, 4'd1, 4'b0000, 32'h0,         32'hAA22_3344};
        vecs[5]  = '{1'b0, 6'd0,  4'd1, 4'b0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[6]  = '{1'b1, 6'd0,  4'd1, 4'b0000, 32'h0,         32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, 6'd63, 4'd1, 4'b0110, 32'h1234_5678, 32'hFF34_56FF};
        vecs[8]  = '{1'b1, 6'd63, 4'd1, 4'b0000, 32'h0,         32'hFF34_56FF};
        vecs[9]  = '{1'b0, 6'd21, 4'd0, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 6'd21, 4'd0, 4'b0000, 32'h0,         32'hCAFE_F00D};
        vecs[11] = '{1'b1, 6'd22, 4'd1, 4'b0000, 32'h0,         32'hFFFF_FFFF};

        // Reset state
        #3;
        chk("rst waitrequest", 32'(waitrequest), 32'd0);
        chk("rst readdatavalid", 32'(readdatavalid), 32'd0);
        chk("rst readdata", readdata, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Preload all ones
        i_write_all = 1'b1;
        tick();
        i_write_all = 1'b0;
        chk("preload word5", word(5), 32'hFFFF_FFFF);

        // Single-beat vectors
        for (int i = 0; i < 12; i++) begin
            address    = vecs[i].adr;
            burstcount = vecs[i].bc;
            byteenable = vecs[i].be;
            writedata  = vecs[i].wd;
            if (!vecs[i].is_rd) begin
                write = 1'b1;
                tick();
                write = 1'b0;
                chk($sformatf("vec%0d word", i), word(int'(vecs[i].adr)), vecs[i].exp);
            end else begin
                read = 1'b1;
                #1 chk($sformatf("vec%0d waitreq", i), 32'(waitrequest), 32'd0);
                tick();
                read = 1'b0;
                repeat (LAT - 2) tick();
                chk($sformatf("vec%0d early valid", i), 32'(readdatavalid), 32'd0);
                tick();
                chk($sformatf("vec%0d valid", i), 32'(readdatavalid), 32'd1);
                chk($sformatf("vec%0d data", i), readdata, vecs[i].exp);
                tick();
                chk($sformatf("vec%0d valid drop", i), 32'(readdatavalid), 32'd0);
                chk($sformatf("vec%0d data hold", i), readdata, vecs[i].exp);
            end
        end

        // Write burst wrapping 62,63,0,1 with a gap; address input ignored after beat 0
        byteenable = 4'hF;
        address    = 6'd62;
        burstcount = 4'd4;
        writedata  = 32'd1;
        write      = 1'b1;
        tick();
        chk("wrburst waitreq", 32'(waitrequest), 32'd0);
        address   = 6'd5;
        writedata = 32'd2;
        tick();
        write = 1'b0;
        tick();
        write     = 1'b1;
        writedata = 32'd3;
        tick();
        writedata = 32'd4;
        tick();
        write = 1'b0;
        chk("wrburst w62", word(62), 32'd1);
        chk("wrburst w63", word(63), 32'd2);
        chk("wrburst w0", word(0), 32'd3);
        chk("wrburst w1", word(1), 32'd4);
        chk("wrburst w5 untouched", word(5), 32'hFFA5_FF34);
        address    = 6'd3;
        burstcount = 4'd1;
        writedata  = 32'h77;
        write      = 1'b1;
        tick();
        write = 1'b0;
        chk("post-burst idle write", word(3), 32'h77);

        // Bulk load i*3
        for (int i = 0; i < SZ; i++) i_in_ram[i*DW +: DW] = 32'(i * 3);
        i_write_all = 1'b1;
        tick();
        i_write_all = 1'b0;
        for (int i = 0; i < SZ; i++) chk($sformatf("bulk word%0d", i), word(i), 32'(i * 3));

        // Read burst 60..63,0..3
        address    = 6'd60;
        burstcount = 4'd8;
        read       = 1'b1;
        #1 chk("rdburst issue waitreq", 32'(waitrequest), 32'd0);
        for (int c = 1; c <= 7 + LAT + 1; c++) begin
            tick();
            read = 1'b0;
            chk($sformatf("rdburst c%0d waitreq", c), 32'(waitrequest), 32'(c <= 7));
            chk($sformatf("rdburst c%0d valid", c), 32'(readdatavalid),
                32'(c >= LAT && c < LAT + 8));
            if (c >= LAT && c < LAT + 8)
                chk($sformatf("rdburst c%0d data", c), readdata, 32'(((60 + c - LAT) % SZ) * 3));
        end

        // Bulk strobe during WR_BURST is ignored
        address    = 6'd40;
        burstcount = 4'd2;
        writedata  = 32'hDEAD;
        write      = 1'b1;
        tick();
        write       = 1'b0;
        i_in_ram    = '0;
        i_write_all = 1'b1;
        tick();
        i_write_all = 1'b0;
        chk("bulk ignored w1", word(1), 32'd3);
        chk("bulk ignored w40", word(40), 32'hDEAD);
        address   = 6'd0;
        writedata = 32'hBEEF;
        write     = 1'b1;
        tick();
        write = 1'b0;
        chk("wrburst2 w41", word(41), 32'hBEEF);

        // Read+write conflict: write wins, no read data
        address    = 6'd7;
        burstcount = 4'd1;
        writedata  = 32'h55;
        read       = 1'b1;
        write      = 1'b1;
        tick();
        read  = 1'b0;
        write = 1'b0;
        chk("conflict w7", word(7), 32'h55);
        for (int k = 1; k <= LAT + 1; k++) begin
            chk($sformatf("conflict k%0d no valid", k), 32'(readdatavalid), 32'd0);
            tick();
        end

        // Reset mid read burst
        address    = 6'd2;
        burstcount = 4'd4;
        read       = 1'b1;
        tick();
        read = 1'b0;
        tick();
        tick();
        chk("midrst waitreq before", 32'(waitrequest), 32'd1);
        chk("midrst valid before", 32'(readdatavalid), 32'd1);
        chk("midrst data before", readdata, 32'd6);
        rst_n_i = 1'b0;
        #1;
        chk("midrst valid async", 32'(readdatavalid), 32'd0);
        chk("midrst waitreq", 32'(waitrequest), 32'd0);
        chk("midrst readdata", readdata, 32'd0);
        tick();
        tick();
        rst_n_i    = 1'b1;
        address    = 6'd9;
        burstcount = 4'd1;
        read       = 1'b1;
        tick();
        read = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            chk($sformatf("postrst k%0d valid", k), 32'(readdatavalid), 32'(k == LAT));
            if (k == LAT) chk("postrst data", readdata, 32'd27);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
